// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator-table address sequencer: derived sizes for the
// default configuration, FSM state encoding and the table address formula.
package accum_pkg;

    localparam int DEF_MAX_OUT_ROWS = 128;
    localparam int DEF_MAX_OUT_COLS = 128;
    localparam int DEF_SYS_ARR_ROWS = 16;
    localparam int DEF_SYS_ARR_COLS = 16;
    localparam int DEF_MAX_K_PASSES = 16;

    localparam int NUM_ACCUM_ROWS = DEF_MAX_OUT_ROWS * (DEF_MAX_OUT_COLS / DEF_SYS_ARR_COLS);
    localparam int AW = $clog2(NUM_ACCUM_ROWS);
    localparam int MW = $clog2(DEF_MAX_OUT_ROWS / DEF_SYS_ARR_ROWS) + 1;
    localparam int NW = $clog2(DEF_MAX_OUT_COLS / DEF_SYS_ARR_COLS) + 1;
    localparam int KW = $clog2(DEF_MAX_K_PASSES) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Each tile column owns a MAX_OUT_ROWS-deep slab; tile rows stack within it.
    function automatic int calc_addr(input int n, input int m, input int sub_row,
                                     input logic rev, input int max_rows, input int sa_rows);
        int row_off;
        row_off = rev ? (sa_rows - 1 - sub_row) : sub_row;
        return n * max_rows + m * sa_rows + row_off;
    endfunction

endpackage

// File: rtl/accum_addr_skew_pipe.sv
// Column skew line: column c sees the {wr_en, accum, addr} launched c cycles after column 0.
// Column 0 holds addr/accum across bubbles so idle columns keep a stable address.
module accum_addr_skew_pipe #(
    parameter int COLS = 16,
    parameter int AW   = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_wr_en,
    input  logic                 in_accum,
    input  logic [AW-1:0]        in_addr,
    output logic [COLS*AW-1:0]   col_addr,
    output logic [COLS-1:0]      col_wr_en,
    output logic [COLS-1:0]      col_accum
);

    logic [COLS-1:0] wr_en_q;
    logic [COLS-1:0] accum_q;
    logic [AW-1:0]   addr_q [COLS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q <= '0;
            accum_q <= '0;
            for (int i = 0; i < COLS; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            wr_en_q[0] <= in_wr_en;
            if (in_wr_en) begin
                accum_q[0] <= in_accum;
                addr_q[0]  <= in_addr;
            end
            for (int i = 1; i < COLS; i++) begin
                wr_en_q[i] <= wr_en_q[i-1];
                accum_q[i] <= accum_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : gen_col
            assign col_addr[gi*AW +: AW] = addr_q[gi];
        end
    endgenerate

    assign col_wr_en = wr_en_q;
    assign col_accum = accum_q;

endmodule

// File: rtl/accum_addr_sequencer.sv
// Walks sub_row / K-pass / tile-row / tile-col per systolic-array output beat and feeds the
// per-column accumulator write port skew line.
module accum_addr_sequencer
    import accum_pkg::*;
#(
    parameter  int MAX_OUT_ROWS = 128,
    parameter  int MAX_OUT_COLS = 128,
    parameter  int SYS_ARR_ROWS = 16,
    parameter  int SYS_ARR_COLS = 16,
    parameter  int MAX_K_PASSES = 16,
    localparam int NUM_ROWS_L   = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
    localparam int AW_L         = $clog2(NUM_ROWS_L),
    localparam int MW_L         = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS) + 1,
    localparam int NW_L         = $clog2(MAX_OUT_COLS / SYS_ARR_COLS) + 1,
    localparam int KW_L         = $clog2(MAX_K_PASSES) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [MW_L-1:0]              cfg_submats_m,
    input  logic [NW_L-1:0]              cfg_submats_n,
    input  logic [KW_L-1:0]              cfg_k_passes,
    input  logic                         cfg_row_rev,
    input  logic                         sa_out_valid,
    output logic [SYS_ARR_COLS*AW_L-1:0] col_addr,
    output logic [SYS_ARR_COLS-1:0]      col_wr_en,
    output logic [SYS_ARR_COLS-1:0]      col_accum,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int MAX_M = MAX_OUT_ROWS / SYS_ARR_ROWS;
    localparam int MAX_N = MAX_OUT_COLS / SYS_ARR_COLS;
    localparam int RW    = (SYS_ARR_ROWS > 1) ? $clog2(SYS_ARR_ROWS) : 1;
    localparam int DW    = (SYS_ARR_COLS > 1) ? $clog2(SYS_ARR_COLS) : 1;

    state_t          state_q, state_d;
    logic [RW-1:0]   sub_row_q, sub_row_d;
    logic [KW_L-1:0] k_q, k_d;
    logic [MW_L-1:0] m_q, m_d;
    logic [NW_L-1:0] n_q, n_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [MW_L-1:0] cfg_m_q, cfg_m_d;
    logic [NW_L-1:0] cfg_n_q, cfg_n_d;
    logic [KW_L-1:0] cfg_k_q, cfg_k_d;
    logic            cfg_rev_q, cfg_rev_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            beat;
    logic            cfg_ok;
    logic            row_last, k_last, m_last, n_last;
    logic [AW_L-1:0] beat_addr;

    assign cfg_ok = (cfg_submats_m != '0) && (32'(cfg_submats_m) <= 32'(MAX_M)) &&
                    (cfg_submats_n != '0) && (32'(cfg_submats_n) <= 32'(MAX_N)) &&
                    (cfg_k_passes  != '0) && (32'(cfg_k_passes)  <= 32'(MAX_K_PASSES));

    assign row_last = (sub_row_q == RW'(SYS_ARR_ROWS - 1));
    assign k_last   = (k_q == cfg_k_q - KW_L'(1));
    assign m_last   = (m_q == cfg_m_q - MW_L'(1));
    assign n_last   = (n_q == cfg_n_q - NW_L'(1));

    assign beat_addr = AW_L'(calc_addr(32'(n_q), 32'(m_q), 32'(sub_row_q), cfg_rev_q,
                                       MAX_OUT_ROWS, SYS_ARR_ROWS));

    always_comb begin
        state_d   = state_q;
        sub_row_d = sub_row_q;
        k_d       = k_q;
        m_d       = m_q;
        n_d       = n_q;
        drain_d   = drain_q;
        cfg_m_d   = cfg_m_q;
        cfg_n_d   = cfg_n_q;
        cfg_k_d   = cfg_k_q;
        cfg_rev_d = cfg_rev_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        beat      = 1'b0;

        case (state_q)
            IDLE: begin
                err_d = sa_out_valid;
                if (start) begin
                    if (cfg_ok) begin
                        cfg_m_d   = cfg_submats_m;
                        cfg_n_d   = cfg_submats_n;
                        cfg_k_d   = cfg_k_passes;
                        cfg_rev_d = cfg_row_rev;
                        sub_row_d = '0;
                        k_d       = '0;
                        m_d       = '0;
                        n_d       = '0;
                        state_d   = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (sa_out_valid) begin
                    beat = 1'b1;
                    // Odometer carry: each counter advances only when all inner ones wrap.
                    if (!row_last) begin
                        sub_row_d = sub_row_q + RW'(1);
                    end else begin
                        sub_row_d = '0;
                        if (!k_last) begin
                            k_d = k_q + KW_L'(1);
                        end else begin
                            k_d = '0;
                            if (!m_last) begin
                                m_d = m_q + MW_L'(1);
                            end else begin
                                m_d = '0;
                                if (!n_last) begin
                                    n_d = n_q + NW_L'(1);
                                end else begin
                                    n_d = '0;
                                    if (SYS_ARR_COLS == 1) begin
                                        state_d = IDLE;
                                        done_d  = 1'b1;
                                    end else begin
                                        state_d = DRAIN;
                                        drain_d = '0;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                err_d   = sa_out_valid;
                drain_d = drain_q + DW'(1);
                if (drain_q == DW'(SYS_ARR_COLS - 2)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sub_row_q <= '0;
            k_q       <= '0;
            m_q       <= '0;
            n_q       <= '0;
            drain_q   <= '0;
            cfg_m_q   <= '0;
            cfg_n_q   <= '0;
            cfg_k_q   <= '0;
            cfg_rev_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sub_row_q <= sub_row_d;
            k_q       <= k_d;
            m_q       <= m_d;
            n_q       <= n_d;
            drain_q   <= drain_d;
            cfg_m_q   <= cfg_m_d;
            cfg_n_q   <= cfg_n_d;
            cfg_k_q   <= cfg_k_d;
            cfg_rev_q <= cfg_rev_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    accum_addr_skew_pipe #(
        .COLS (SYS_ARR_COLS),
        .AW   (AW_L)
    ) u_skew (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_wr_en  (beat),
        .in_accum  (k_q != '0),
        .in_addr   (beat_addr),
        .col_addr  (col_addr),
        .col_wr_en (col_wr_en),
        .col_accum (col_accum)
    );

    // The done cycle is already IDLE, yet still counts as part of the job.
    assign busy = (state_q != IDLE) || done_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_accum_addr_sequencer.sv
// Randomized bench for accum_addr_sequencer (8x8 output, 4x4 array) against a job-list model.
module tb_accum_addr_sequencer;

    localparam int OR = 8, OC = 8, SR = 4, SC = 4, MK = 16;
    localparam int AW = 4, MW = 2, NW = 2, KW = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          acc;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [MW-1:0]      cfg_m = '0;
    logic [NW-1:0]      cfg_n = '0;
    logic [KW-1:0]      cfg_k = '0;
    logic               cfg_rev = 1'b0;
    logic               valid = 1'b0;
    logic [SC*AW-1:0]   col_addr;
    logic [SC-1:0]      col_wr_en;
    logic [SC-1:0]      col_accum;
    logic               busy, done, err;

    int checks = 0;
    int errors = 0;

    // Model state: pending writes of the active job, per-column delay history of column 0.
    wr_t           exp_q[$];
    int            mode = 0;   // 0 idle, 1 taking beats, 2 waiting for last column
    int            cd = -1;
    logic          exp_done = 1'b0, exp_err = 1'b0;
    logic          hist_wr[SC];
    logic [AW-1:0] hist_addr[SC];
    logic          hist_acc[SC];
    int            done_seen = 0;

    always #5 clk = ~clk;

    accum_addr_sequencer #(
        .MAX_OUT_ROWS (OR),
        .MAX_OUT_COLS (OC),
        .SYS_ARR_ROWS (SR),
        .SYS_ARR_COLS (SC),
        .MAX_K_PASSES (MK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_submats_m (cfg_m),
        .cfg_submats_n (cfg_n),
        .cfg_k_passes  (cfg_k),
        .cfg_row_rev   (cfg_rev),
        .sa_out_valid  (valid),
        .col_addr      (col_addr),
        .col_wr_en     (col_wr_en),
        .col_accum     (col_accum),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic cfg_good(input int m, input int n, input int k);
        return (m >= 1 && m <= OR / SR && n >= 1 && n <= OC / SC && k >= 1 && k <= MK);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        mode     = 0;
        cd       = -1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int c = 0; c < SC; c++) begin
            hist_wr[c]   = 1'b0;
            hist_addr[c] = '0;
            hist_acc[c]  = 1'b0;
        end
    endtask

    // Applies one clock edge worth of spec rules to the model, using inputs as sampled.
    task automatic model_edge(input logic st, input logic v);
        logic new_wr;
        wr_t  w;
        new_wr = 1'b0;
        w      = '0;
        if (!rst_n) begin
            model_clear();
            return;
        end
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (mode == 0) begin
            if (v) exp_err = 1'b1;
            if (st) begin
                if (cfg_good(int'(cfg_m), int'(cfg_n), int'(cfg_k))) begin
                    for (int n = 0; n < int'(cfg_n); n++)
                        for (int m = 0; m < int'(cfg_m); m++)
                            for (int k = 0; k < int'(cfg_k); k++)
                                for (int r = 0; r < SR; r++) begin
                                    wr_t e;
                                    e.addr = AW'(n * OR + m * SR + (cfg_rev ? SR - 1 - r : r));
                                    e.acc  = (k != 0);
                                    exp_q.push_back(e);
                                end
                    mode = 1;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end else if (mode == 1) begin
            if (v) begin
                w      = exp_q.pop_front();
                new_wr = 1'b1;
                if (exp_q.size() == 0) begin
                    mode = 2;
                    cd   = SC - 1;
                    if (cd == 0) begin
                        exp_done = 1'b1;
                        mode     = 0;
                    end
                end
            end
        end else begin
            if (v) exp_err = 1'b1;
            cd--;
            if (cd == 0) begin
                exp_done = 1'b1;
                mode     = 0;
            end
        end
        for (int c = SC - 1; c > 0; c--) begin
            hist_wr[c]   = hist_wr[c-1];
            hist_addr[c] = hist_addr[c-1];
            hist_acc[c]  = hist_acc[c-1];
        end
        hist_wr[0] = new_wr;
        if (new_wr) begin
            hist_addr[0] = w.addr;
            hist_acc[0]  = w.acc;
        end
    endtask

    task automatic cycle(input logic st, input logic v);
        logic [SC*AW-1:0] ea;
        logic [SC-1:0]    ew, ec;
        start = st;
        valid = v;
        @(posedge clk);
        model_edge(st, v);
        @(negedge clk);
        for (int c = 0; c < SC; c++) begin
            ea[c*AW +: AW] = hist_addr[c];
            ew[c]          = hist_wr[c];
            ec[c]          = hist_acc[c];
        end
        check("wr_en", 64'(col_wr_en), 64'(ew));
        check("addr",  64'(col_addr),  64'(ea));
        check("accum", 64'(col_accum), 64'(ec));
        check("busy",  64'(busy), 64'(mode != 0 || exp_done));
        check("done",  64'(done), 64'(exp_done));
        check("err",   64'(err),  64'(exp_err));
        if (exp_done) done_seen++;
        start = 1'b0;
        valid = 1'b0;
    endtask

    // One job: start, then beats with probability pct; stray = random start/late beats.
    task automatic run_job(input int m, input int n, input int k, input logic rev,
                           input int pct, input logic stray);
        int budget, ncyc, d0;
        logic v, s;
        cfg_m   = MW'(m);
        cfg_n   = NW'(n);
        cfg_k   = KW'(k);
        cfg_rev = rev;
        d0      = done_seen;
        cycle(1'b1, 1'b0);
        budget = 4000;
        ncyc   = 0;
        while (mode != 0 && budget > 0) begin
            if (mode == 1) v = ($urandom_range(99) < pct);
            else           v = stray && ($urandom_range(7) == 0);
            s = stray && ($urandom_range(9) == 0);
            cycle(s, v);
            budget--;
            ncyc++;
        end
        check("job_timeout", 64'(budget == 0), 64'(0));
        if (cfg_good(m, n, k)) check("done_count", 64'(done_seen - d0), 64'(1));
        $display("job m=%0d n=%0d k=%0d rev=%0d pct=%0d cycles=%0d", m, n, k, rev, pct, ncyc);
        cycle(1'b0, 1'b0);
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0;
        repeat (3) cycle(1'b0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0);

        run_job(2, 2, 1, 1'b0, 100, 1'b0);
        run_job(1, 1, 3, 1'b0, 100, 1'b0);
        run_job(1, 2, 1, 1'b1, 100, 1'b0);
        run_job(2, 1, 2, 1'b0, 50, 1'b0);

        // Rejected configurations and a stray beat in IDLE.
        run_job(1, 1, 0, 1'b0, 100, 1'b0);
        run_job(0, 1, 1, 1'b0, 100, 1'b0);
        run_job(1, 3, 1, 1'b0, 100, 1'b0);
        run_job(3, 1, 1, 1'b0, 100, 1'b0);
        run_job(1, 1, 17, 1'b0, 100, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // Abort mid-job with reset, then restart from the first address.
        cfg_m = 2'd2; cfg_n = 2'd2; cfg_k = 5'd1; cfg_rev = 1'b0;
        cycle(1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b1);
        rst_n = 1'b0;
        cycle(1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (SC + 1) cycle(1'b0, 1'b0);
        check("abort_done", 64'(done_seen), 64'(4));
        run_job(2, 2, 1, 1'b0, 100, 1'b0);

        for (int j = 0; j < 30; j++) begin
            run_job($urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(1, 4),
                    1'($urandom_range(1)), $urandom_range(30, 100), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
